// File: rtl/irq_stack_sequencer.sv
// irq_stack_sequencer
// -------------------
// Multi-cycle sequencer for interrupt entry and RTI return in the decode stage.
//
// On interrupt entry it freezes fetch and the control unit, then works through
// these steps:
//   - push the return PC as two 16-bit words, low word first;
//   - push the CCR;
//   - read the 32-bit ISR vector from VEC_ADDR and VEC_ADDR+1;
//   - load the vector into the PC.
//
// On RTI it pops the CCR, then the PC high word, then the PC low word, and
// restores them.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   interrupt, rti    : sequence requests
//   load_use          : load-use stall; blocks a sequence from starting
//   mem_ready         : the stack/memory port completes the current access
//   pc_in, ccr_in     : return address and flags captured at entry
//   mem_rdata         : stack pop / vector read data (valid with mem_ready)
//   stack_push/pop,
//   stack_wdata       : stack port requests
//   vec_rd, vec_addr  : vector read request
//   pc_load, pc_new   : one-cycle PC load strobe and value
//   ccr_load, ccr_new : one-cycle CCR restore strobe and value
//   fetch_pc_enable   : fetch PC may advance
//   freeze_cu, busy   : high whenever the sequencer is out of IDLE
module irq_stack_sequencer #(
  parameter int          PC_WIDTH = 32,
  parameter logic [15:0] VEC_ADDR = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interrupt,
  input  logic                rti,
  input  logic                load_use,
  input  logic                mem_ready,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [2:0]          ccr_in,
  input  logic [15:0]         mem_rdata,
  output logic                stack_push,
  output logic                stack_pop,
  output logic [15:0]         stack_wdata,
  output logic                vec_rd,
  output logic [15:0]         vec_addr,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_new,
  output logic                ccr_load,
  output logic [2:0]          ccr_new,
  output logic                fetch_pc_enable,
  output logic                freeze_cu,
  output logic                busy
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PUSH_LO  = 4'd1,
    PUSH_HI  = 4'd2,
    PUSH_CCR = 4'd3,
    VEC_LO   = 4'd4,
    VEC_HI   = 4'd5,
    LOAD_PC  = 4'd6,
    POP_CCR  = 4'd7,
    POP_HI   = 4'd8,
    POP_LO   = 4'd9,
    RET_PC   = 4'd10
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic                int_pending_r;
  logic [PC_WIDTH-1:0] ret_pc_r;
  logic [2:0]          sav_ccr_r;
  logic [15:0]         pc_hi_r;
  logic [15:0]         pc_lo_r;
  logic                idle_go_s;
  logic                start_rti_s;
  logic                take_int_s;

  // Start decisions in IDLE: RTI has priority, a waiting interrupt stays pending.
  always_comb begin
    idle_go_s   = (state_r == IDLE) && !load_use;
    start_rti_s = idle_go_s && rti;
    take_int_s  = idle_go_s && !rti && (interrupt || int_pending_r);
  end

  // Next-state logic; every memory state holds until mem_ready.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_rti_s) begin
          state_nx_s = POP_CCR;
        end else if (take_int_s) begin
          state_nx_s = PUSH_LO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PUSH_LO:  state_nx_s = mem_ready ? PUSH_HI  : PUSH_LO;
      PUSH_HI:  state_nx_s = mem_ready ? PUSH_CCR : PUSH_HI;
      PUSH_CCR: state_nx_s = mem_ready ? VEC_LO   : PUSH_CCR;
      VEC_LO:   state_nx_s = mem_ready ? VEC_HI   : VEC_LO;
      VEC_HI:   state_nx_s = mem_ready ? LOAD_PC  : VEC_HI;
      LOAD_PC:  state_nx_s = IDLE;
      POP_CCR:  state_nx_s = mem_ready ? POP_HI   : POP_CCR;
      POP_HI:   state_nx_s = mem_ready ? POP_LO   : POP_HI;
      POP_LO:   state_nx_s = mem_ready ? RET_PC   : POP_LO;
      RET_PC:   state_nx_s = IDLE;
      default:  state_nx_s = IDLE;
    endcase
  end

  // State register, pending-interrupt latch and captured data words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      int_pending_r <= 1'b0;
      ret_pc_r      <= '0;
      sav_ccr_r     <= 3'b000;
      pc_hi_r       <= 16'h0000;
      pc_lo_r       <= 16'h0000;
    end else begin
      state_r <= state_nx_s;
      // Requests collapse into one pending flag, cleared when entry starts.
      int_pending_r <= take_int_s ? 1'b0 : (int_pending_r | interrupt);
      if (take_int_s) begin
        ret_pc_r  <= pc_in;
        sav_ccr_r <= ccr_in;
      end
      if (mem_ready && ((state_r == VEC_LO) || (state_r == POP_LO))) begin
        pc_lo_r <= mem_rdata;
      end
      if (mem_ready && ((state_r == VEC_HI) || (state_r == POP_HI))) begin
        pc_hi_r <= mem_rdata;
      end
    end
  end

  // Output decode from the registered state; only the CCR restore looks at mem_ready.
  always_comb begin
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    stack_wdata = 16'h0000;
    vec_rd      = 1'b0;
    vec_addr    = 16'h0000;
    pc_load     = 1'b0;
    pc_new      = '0;
    ccr_load    = 1'b0;
    ccr_new     = 3'b000;
    case (state_r)
      PUSH_LO: begin
        stack_push  = 1'b1;
        stack_wdata = ret_pc_r[15:0];
      end
      PUSH_HI: begin
        stack_push  = 1'b1;
        stack_wdata = ret_pc_r[31:16];
      end
      PUSH_CCR: begin
        stack_push  = 1'b1;
        stack_wdata = {13'b0, sav_ccr_r};
      end
      VEC_LO: begin
        vec_rd   = 1'b1;
        vec_addr = VEC_ADDR;
      end
      VEC_HI: begin
        vec_rd   = 1'b1;
        vec_addr = VEC_ADDR + 16'd1;
      end
      POP_CCR: begin
        stack_pop = 1'b1;
        if (mem_ready) begin
          ccr_load = 1'b1;
          ccr_new  = mem_rdata[2:0];
        end else begin
          ccr_load = 1'b0;
          ccr_new  = 3'b000;
        end
      end
      POP_HI, POP_LO: begin
        stack_pop = 1'b1;
      end
      LOAD_PC, RET_PC: begin
        pc_load = 1'b1;
        pc_new  = {pc_hi_r, pc_lo_r};
      end
      default: begin
        stack_push = 1'b0;
      end
    endcase
  end

  // Pipeline handshake: fetch only advances from an unstalled IDLE.
  always_comb begin
    busy            = (state_r != IDLE);
    freeze_cu       = (state_r != IDLE);
    fetch_pc_enable = (state_r == IDLE) && !load_use;
  end

endmodule

// File: tb/tb_irq_stack_sequencer.sv
// Directed testbench for irq_stack_sequencer.
// Inputs are driven just after each falling edge and outputs are sampled 1 ns
// later, well away from the rising edge.
module tb_irq_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt;
  logic        rti;
  logic        load_use;
  logic        mem_ready;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in;
  logic [15:0] mem_rdata;
  logic        stack_push;
  logic        stack_pop;
  logic [15:0] stack_wdata;
  logic        vec_rd;
  logic [15:0] vec_addr;
  logic        pc_load;
  logic [31:0] pc_new;
  logic        ccr_load;
  logic [2:0]  ccr_new;
  logic        fetch_pc_enable;
  logic        freeze_cu;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  irq_stack_sequencer #(.PC_WIDTH(32), .VEC_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .rti(rti), .load_use(load_use),
    .mem_ready(mem_ready), .pc_in(pc_in), .ccr_in(ccr_in), .mem_rdata(mem_rdata),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_wdata(stack_wdata),
    .vec_rd(vec_rd), .vec_addr(vec_addr), .pc_load(pc_load), .pc_new(pc_new),
    .ccr_load(ccr_load), .ccr_new(ccr_new), .fetch_pc_enable(fetch_pc_enable),
    .freeze_cu(freeze_cu), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let outputs settle after the inputs of this cycle and count busy cycles.
  task automatic look();
    #1;
    if (busy === 1'b1) busy_cnt++;
  endtask

  // One cycle of a push state with mem_ready=1.
  task automatic push_cycle(input string tag, input logic [15:0] data);
    @(negedge clk); interrupt = 1'b0; mem_ready = 1'b1; look();
    chk({tag, "_push"}, {31'd0, stack_push}, 32'd1);
    chk({tag, "_wdata"}, {16'd0, stack_wdata}, {16'd0, data});
  endtask

  // One cycle of a vector read with mem_ready=1 returning rdata.
  task automatic vec_cycle(input string tag, input logic [15:0] addr, input logic [15:0] rdata);
    @(negedge clk); interrupt = 1'b0; mem_ready = 1'b1; mem_rdata = rdata; look();
    chk({tag, "_rd"}, {31'd0, vec_rd}, 32'd1);
    chk({tag, "_addr"}, {16'd0, vec_addr}, {16'd0, addr});
  endtask

  // Vector reads from memory[0]=0100, memory[1]=0000, then the LOAD_PC cycle.
  task automatic vec_and_load(input string tag);
    vec_cycle({tag, "_veclo"}, 16'h0000, 16'h0100);
    vec_cycle({tag, "_vechi"}, 16'h0001, 16'h0000);
    @(negedge clk); mem_rdata = 16'h0000; look();
    chk({tag, "_pc_load"}, {31'd0, pc_load}, 32'd1);
    chk({tag, "_pc_new"}, pc_new, 32'h0000_0100);
  endtask

  // Full RTI sequence popping CCR=3, PC=0001_2345.
  task automatic rti_seq(input string tag);
    @(negedge clk); rti = 1'b0; interrupt = 1'b0; mem_rdata = 16'h0003; look();
    chk({tag, "_pop_ccr"}, {31'd0, stack_pop}, 32'd1);
    chk({tag, "_no_push"}, {31'd0, stack_push}, 32'd0);
    chk({tag, "_ccr_load"}, {31'd0, ccr_load}, 32'd1);
    chk({tag, "_ccr_new"}, {29'd0, ccr_new}, 32'd3);
    @(negedge clk); mem_rdata = 16'h0001; look();
    chk({tag, "_pop_hi"}, {31'd0, stack_pop}, 32'd1);
    chk({tag, "_ccr_load_off"}, {31'd0, ccr_load}, 32'd0);
    chk({tag, "_ccr_new_off"}, {29'd0, ccr_new}, 32'd0);
    @(negedge clk); mem_rdata = 16'h2345; look();
    chk({tag, "_pop_lo"}, {31'd0, stack_pop}, 32'd1);
    @(negedge clk); mem_rdata = 16'h0000; look();
    chk({tag, "_ret_pc_load"}, {31'd0, pc_load}, 32'd1);
    chk({tag, "_ret_pc_new"}, pc_new, 32'h0001_2345);
  endtask

  initial begin
    rst = 1'b1; interrupt = 1'b0; rti = 1'b0; load_use = 1'b0; mem_ready = 1'b1;
    pc_in = 32'h0; ccr_in = 3'b000; mem_rdata = 16'h0000;

    // Reset state
    @(negedge clk); @(negedge clk); look();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_freeze", {31'd0, freeze_cu}, 32'd0);
    chk("rst_push", {31'd0, stack_push}, 32'd0);
    chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst_fetch", {31'd0, fetch_pc_enable}, 32'd1);
    @(negedge clk); load_use = 1'b1; look();
    chk("rst_fetch_lu", {31'd0, fetch_pc_enable}, 32'd0);

    // Basic entry
    @(negedge clk); rst = 1'b0; load_use = 1'b0;
    pc_in = 32'h0001_2345; ccr_in = 3'b101; interrupt = 1'b1;
    busy_cnt = 0; look();
    chk("e1_idle", {31'd0, busy}, 32'd0);
    push_cycle("e1_lo", 16'h2345);
    chk("e1_freeze", {31'd0, freeze_cu}, 32'd1);
    chk("e1_no_fetch", {31'd0, fetch_pc_enable}, 32'd0);
    push_cycle("e1_hi", 16'h0001);
    push_cycle("e1_ccr", 16'h0005);
    vec_and_load("e1");
    @(negedge clk); rti = 1'b1; look();
    chk("e1_back_idle", {31'd0, busy}, 32'd0);
    chk("e1_busy_cycles", busy_cnt, 32'd6);

    // RTI
    rti_seq("r1");
    @(negedge clk); look();
    chk("r1_back_idle", {31'd0, busy}, 32'd0);

    // Wait states during PUSH_HI
    interrupt = 1'b1; busy_cnt = 0;
    push_cycle("w_lo", 16'h2345);
    @(negedge clk); mem_ready = 1'b0; look();
    chk("w_hi_wait1", {16'd0, stack_wdata}, 32'h0001);
    @(negedge clk); mem_ready = 1'b0; look();
    chk("w_hi_wait2", {16'd0, stack_wdata}, 32'h0001);
    chk("w_hi_wait2_push", {31'd0, stack_push}, 32'd1);
    push_cycle("w_hi", 16'h0001);
    push_cycle("w_ccr", 16'h0005);
    vec_and_load("w");
    @(negedge clk); rti = 1'b1; interrupt = 1'b1; look();
    chk("w_busy_cycles", busy_cnt, 32'd8);

    // Priority: rti and interrupt together, RTI first
    rti_seq("p");
    @(negedge clk); pc_in = 32'h00AB_CDEF; ccr_in = 3'b010; look();
    chk("p_gap_idle", {31'd0, busy}, 32'd0);
    @(negedge clk); interrupt = 1'b1; look();
    chk("p_e_lo_push", {31'd0, stack_push}, 32'd1);
    chk("p_e_lo_wdata", {16'd0, stack_wdata}, 32'h0000_CDEF);
    push_cycle("p_e_hi", 16'h00AB);
    push_cycle("p_e_ccr", 16'h0002);
    vec_and_load("p_e");
    @(negedge clk); look();
    chk("p_gap2_idle", {31'd0, busy}, 32'd0);
    push_cycle("p_e2_lo", 16'hCDEF);
    push_cycle("p_e2_hi", 16'h00AB);
    push_cycle("p_e2_ccr", 16'h0002);
    vec_and_load("p_e2");
    @(negedge clk); look();
    chk("p_after_idle", {31'd0, busy}, 32'd0);
    @(negedge clk); look();
    chk("p_no_third_entry", {31'd0, busy}, 32'd0);

    // load_use blocks the start for 3 cycles
    @(negedge clk); interrupt = 1'b1; load_use = 1'b1; look();
    chk("lu1_fetch", {31'd0, fetch_pc_enable}, 32'd0);
    chk("lu1_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); interrupt = 1'b0; look();
    chk("lu2_fetch", {31'd0, fetch_pc_enable}, 32'd0);
    chk("lu2_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); look();
    chk("lu3_fetch", {31'd0, fetch_pc_enable}, 32'd0);
    chk("lu3_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); load_use = 1'b0; look();
    chk("lu_drop_busy", {31'd0, busy}, 32'd0);
    chk("lu_drop_fetch", {31'd0, fetch_pc_enable}, 32'd1);
    push_cycle("lu_lo", 16'hCDEF);

    // Reset during VEC_LO
    push_cycle("rs_hi", 16'h00AB);
    push_cycle("rs_ccr", 16'h0002);
    @(negedge clk); rst = 1'b1; interrupt = 1'b1; mem_rdata = 16'h0100; look();
    chk("rs_in_veclo", {31'd0, vec_rd}, 32'd1);
    @(negedge clk); rst = 1'b0; interrupt = 1'b0; mem_rdata = 16'h0000; look();
    chk("rs_idle", {31'd0, busy}, 32'd0);
    chk("rs_no_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rs_no_vec_rd", {31'd0, vec_rd}, 32'd0);
    chk("rs_no_push", {31'd0, stack_push}, 32'd0);
    chk("rs_no_pop", {31'd0, stack_pop}, 32'd0);
    chk("rs_fetch", {31'd0, fetch_pc_enable}, 32'd1);
    chk("rs_pending", {31'd0, dut.int_pending_r}, 32'd0);
    @(negedge clk); look();
    chk("rs_stay_idle", {31'd0, busy}, 32'd0);
    chk("rs_stay_no_pc_load", {31'd0, pc_load}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
